// File: rtl/vc_flit_injector.sv
// Credit-aware flit traffic source for one router input port.
// Picks a VC with downstream credit round-robin and stamps each flit with VC, destination and sequence id.
module vc_flit_injector #(
    parameter int          FLIT_W      = 32,
    parameter int          NUM_VC      = 4,
    parameter int          NUM_ROUTERS = 16,
    parameter int          BUF_DEPTH   = 4,
    parameter int          SRC_ID      = 0,
    parameter int          SEQ_W       = 11,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         VC_BITS     = $clog2(NUM_VC),
    localparam int         RID_BITS    = $clog2(NUM_ROUTERS),
    localparam int         CW          = $clog2(BUF_DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    input  logic [RID_BITS-1:0] i_fixed_dst,
    input  logic [7:0]          i_inj_rate,
    input  logic [15:0]         i_num_flits,
    input  logic [NUM_VC-1:0]   i_credit_increment,
    output logic [FLIT_W-1:0]   o_out_data,
    output logic                o_out_valid,
    output logic                o_done,
    output logic [15:0]         o_sent_count,
    output logic [15:0]         o_stall_count,
    output logic                o_credit_err
);

    localparam int                 HALF    = RID_BITS / 2;
    localparam logic [CW-1:0]      FULL    = CW'(BUF_DEPTH);
    localparam logic [RID_BITS-1:0] SRC_RID = RID_BITS'(SRC_ID);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      r_state, w_state_next;
    logic [15:0]                 r_lfsr, w_lfsr_next;
    logic [NUM_VC-1:0][CW-1:0]   r_credit;
    logic [NUM_VC-1:0][CW-1:0]   w_credit_next;
    logic [NUM_VC-1:0]           w_overflow;
    logic [VC_BITS-1:0]          r_rr_ptr;
    logic [SEQ_W-1:0]            r_seq;
    logic [15:0]                 r_sent_count, r_stall_count;
    logic                        r_credit_err;

    logic                        w_found, w_try, w_active, w_send, w_stall;
    logic [VC_BITS-1:0]          w_sel, w_rr_next;
    logic [RID_BITS-1:0]         w_dst;
    logic [FLIT_W-1:0]           w_flit;
    logic [15:0]                 w_sent_inc;

    assign o_sent_count  = r_sent_count;
    assign o_stall_count = r_stall_count;
    assign o_credit_err  = r_credit_err;
    assign o_done        = (r_state == DONE);

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    assign w_try      = (i_inj_rate == 8'hFF) || (r_lfsr[7:0] < i_inj_rate);
    assign w_active   = (r_state == RUN) && i_enable;
    assign w_send     = w_active && w_try && w_found;
    assign w_stall    = w_active && w_try && !w_found;
    assign w_sent_inc = r_sent_count + 16'd1;
    assign w_rr_next  = (int'(w_sel) == NUM_VC - 1) ? '0 : w_sel + VC_BITS'(1);

    // Round-robin search starting at r_rr_ptr for the first VC holding credit.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_VC) idx = idx - NUM_VC;
            if (!w_found && (r_credit[idx] != '0)) begin
                w_found = 1'b1;
                w_sel   = VC_BITS'(idx);
            end
        end
    end

    always_comb begin
        case (i_mode)
            2'd0:    w_dst = r_lfsr[8 +: RID_BITS];
            2'd1:    w_dst = i_fixed_dst;
            2'd2:    w_dst = {SRC_RID[HALF-1:0], SRC_RID[RID_BITS-1:HALF]};
            default: w_dst = ~SRC_RID;
        endcase
    end

    always_comb begin
        w_flit                                = '0;
        w_flit[SEQ_W-1:0]                     = r_seq;
        w_flit[FLIT_W-VC_BITS-1 -: RID_BITS]  = w_dst;
        w_flit[FLIT_W-1 -: VC_BITS]           = w_sel;
    end

    // A send and a returned credit on the same VC cancel out.
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_credit
        logic w_dec;
        logic w_inc;
        assign w_dec          = w_send && (w_sel == VC_BITS'(gi));
        assign w_inc          = i_credit_increment[gi];
        assign w_overflow[gi] = w_inc && !w_dec && (r_credit[gi] == FULL);
        assign w_credit_next[gi] =
            (w_dec && !w_inc)                          ? r_credit[gi] - CW'(1) :
            (w_inc && !w_dec && r_credit[gi] != FULL)  ? r_credit[gi] + CW'(1) :
                                                         r_credit[gi];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_enable) w_state_next = RUN;
            RUN: begin
                if (!i_enable)
                    w_state_next = IDLE;
                else if (w_send && (i_num_flits != 16'd0) && (w_sent_inc == i_num_flits))
                    w_state_next = DONE;
            end
            DONE: if (!i_enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_lfsr        <= LFSR_SEED;
            r_rr_ptr      <= '0;
            r_seq         <= '0;
            r_sent_count  <= '0;
            r_stall_count <= '0;
            r_credit_err  <= 1'b0;
            o_out_valid   <= 1'b0;
            o_out_data    <= '0;
            for (int v = 0; v < NUM_VC; v++) r_credit[v] <= FULL;
        end else begin
            r_state     <= w_state_next;
            o_out_valid <= w_send;
            r_credit    <= w_credit_next;
            if (r_state == RUN) r_lfsr <= w_lfsr_next;
            if (|w_overflow) r_credit_err <= 1'b1;
            if (w_send) begin
                o_out_data <= w_flit;
                r_seq      <= r_seq + SEQ_W'(1);
                r_rr_ptr   <= w_rr_next;
            end
            // Run statistics restart on IDLE -> RUN.
            if ((r_state == IDLE) && i_enable) begin
                r_sent_count  <= '0;
                r_stall_count <= '0;
            end else begin
                if (w_send) r_sent_count <= w_sent_inc;
                if (w_stall && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vc_flit_injector.sv
// Directed bench for vc_flit_injector: fixed runs, credit exhaustion and return,
// overflow flagging, pattern destinations, zero rate and asynchronous reset.
module tb_vc_flit_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [3:0]  fixed_dst;
    logic [7:0]  inj_rate;
    logic [15:0] num_flits;
    logic [3:0]  credit_inc;
    logic [31:0] out_data;
    logic        out_valid, done, credit_err;
    logic [15:0] sent_count, stall_count;

    logic [1:0]  mode2 = 2'd2;
    logic [3:0]  credit_inc2 = 4'd0;
    logic [31:0] out_data2;
    logic        out_valid2, done2, credit_err2;
    logic [15:0] sent_count2, stall_count2;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    always #5 clk = ~clk;

    vc_flit_injector #(.SRC_ID(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_mode(mode),
        .i_fixed_dst(fixed_dst), .i_inj_rate(inj_rate), .i_num_flits(num_flits),
        .i_credit_increment(credit_inc), .o_out_data(out_data), .o_out_valid(out_valid),
        .o_done(done), .o_sent_count(sent_count), .o_stall_count(stall_count),
        .o_credit_err(credit_err)
    );

    vc_flit_injector #(.SRC_ID(1)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_mode(mode2),
        .i_fixed_dst(fixed_dst), .i_inj_rate(inj_rate), .i_num_flits(num_flits),
        .i_credit_increment(credit_inc2), .o_out_data(out_data2), .o_out_valid(out_valid2),
        .o_done(done2), .o_sent_count(sent_count2), .o_stall_count(stall_count2),
        .o_credit_err(credit_err2)
    );

    function automatic logic [31:0] flit(input int vc, input int dst, input int seq);
        logic [1:0]  v;
        logic [3:0]  d;
        logic [10:0] s;
        v = 2'(vc);
        d = 4'(dst);
        s = 11'(seq);
        return {v, d, 15'd0, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'd1; fixed_dst = 4'd5;
        inj_rate = 8'hFF; num_flits = 16'd3; credit_inc = 4'd0;

        // Reset state
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_credit0", 32'(dut.r_credit[0]), 32'd4);
        reset = 1'b0;

        // T1: fixed destination, three flits
        step(); enable = 1'b1;
        step(); chk("t1_idle_gap", 32'(out_valid), 32'd0);
        step(); chk("t1_f0_valid", 32'(out_valid), 32'd1);
        chk("t1_f0", out_data, flit(0, 5, 0));
        chk("t1_dut2_dst", 32'(out_data2[29:26]), 32'd4);
        chk("t1_dut2_valid", 32'(out_valid2), 32'd1);
        step(); chk("t1_f1", out_data, flit(1, 5, 1));
        step(); chk("t1_f2", out_data, flit(2, 5, 2));
        chk("t1_f2_valid", 32'(out_valid), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_sent", 32'(sent_count), 32'd3);
        step(); chk("t1_after_valid", 32'(out_valid), 32'd0);
        chk("t1_done_hold", 32'(done), 32'd1);
        chk("t1_cred3", 32'(dut.r_credit[3]), 32'd4);
        chk("t1_cred2", 32'(dut.r_credit[2]), 32'd3);
        chk("t1_cred0", 32'(dut.r_credit[0]), 32'd3);
        enable = 1'b0;
        step(); chk("t1_done_clr", 32'(done), 32'd0);
        chk("t1_state_idle", 32'(dut.r_state), 32'd0);
        reset = 1'b1;

        // T2: unlimited run drains all 16 credits
        step(); reset = 1'b0; num_flits = 16'd0; enable = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("t2_flits", 32'(cnt), 32'd16);
        chk("t2_sent", 32'(sent_count), 32'd16);
        chk("t2_stall", 32'(stall_count), 32'd13);
        chk("t2_hold_last", out_data, flit(3, 5, 15));

        // T3: single returned credit on vc2
        credit_inc = 4'b0100;
        step(); credit_inc = 4'b0000;
        chk("t3_no_flit_yet", 32'(out_valid), 32'd0);
        chk("t3_stall_inc", 32'(stall_count), 32'd14);
        step(); chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_flit", out_data, flit(2, 5, 16));
        step(); chk("t3_single", 32'(out_valid), 32'd0);
        chk("t3_stall", 32'(stall_count), 32'd15);

        // T4a: send on vc1 while vc1 credit returns
        credit_inc = 4'b0010;
        step(); chk("t4_cred1_one", 32'(dut.r_credit[1]), 32'd1);
        credit_inc = 4'b0010;
        step(); credit_inc = 4'b0000;
        chk("t4_flit_vc1", out_data, flit(1, 5, 17));
        chk("t4_cred1_unch", 32'(dut.r_credit[1]), 32'd1);
        step(); chk("t4_flit_vc1b", out_data, flit(1, 5, 18));
        chk("t4_cred1_zero", 32'(dut.r_credit[1]), 32'd0);
        enable = 1'b0; reset = 1'b1;

        // T4b: increment on a full counter
        step(); reset = 1'b0;
        chk("t4_err_clear", 32'(credit_err), 32'd0);
        credit_inc = 4'b1000;
        step(); credit_inc = 4'b0000;
        chk("t4_cred3_full", 32'(dut.r_credit[3]), 32'd4);
        chk("t4_err_set", 32'(credit_err), 32'd1);
        step(); chk("t4_err_sticky", 32'(credit_err), 32'd1);

        // T5: bit-complement destination, then zero injection rate
        mode = 2'd3; num_flits = 16'd1; enable = 1'b1;
        step();
        step(); chk("t5_mode3", out_data, flit(0, 12, 0));
        chk("t5_done", 32'(done), 32'd1);
        enable = 1'b0;
        step(); inj_rate = 8'd0; num_flits = 16'd0; enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("t5_rate0_flits", 32'(cnt), 32'd0);
        chk("t5_rate0_stall", 32'(stall_count), 32'd0);
        enable = 1'b0; inj_rate = 8'hFF;

        // T6: asynchronous reset mid-cycle during a run
        step(); mode = 2'd1; enable = 1'b1;
        step();
        step(); chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_sent", 32'(sent_count), 32'd0);
        chk("t6_cred0", 32'(dut.r_credit[0]), 32'd4);
        chk("t6_cred1", 32'(dut.r_credit[1]), 32'd4);
        chk("t6_state", 32'(dut.r_state), 32'd0);
        step(); reset = 1'b0; enable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
